// File: rtl/etapa_if.sv
// rtl/etapa_if.sv - MIPS instruction-fetch stage: PC, request/ready fetch, one-entry skid, IF/ID register
// Optional feature macro: IF_FETCH_CNT_EN (adds fetch_cnt / stall_cnt counters)
module etapa_if #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  SEL_DIR,
   input  logic        resetIF,
   input  logic        MEM_RD_I,
   input  logic        stall,
   input  logic [25:0] jump_target,
   input  logic [31:0] jr_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   output logic [31:0] instr_ID,
   output logic [31:0] pc4_ID,
   output logic        valid_ID,
   output logic [5:0]  opcode,
   output logic [5:0]  funct
`ifdef IF_FETCH_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {ARRANQUE = 2'd0, FETCH = 2'd1, RETENCION = 2'd2} estado_t;

   estado_t     estado, estado_sig;
   logic [31:0] pc, pc_plus4, pc_sig, target;
   logic [31:0] skid_instr, skid_pc4;
   logic        transfer, redirect;
   logic        if_load, if_from_skid, if_nop, skid_load;

   assign pc_plus4 = pc + 32'd4;
   assign transfer = imem_req && imem_ready;
   // 11 on SEL_DIR is plain sequential fetch, so only 01/10 redirect
   assign redirect = (estado != ARRANQUE) && ((SEL_DIR == 2'b01) || (SEL_DIR == 2'b10));
   assign target   = (SEL_DIR == 2'b01) ? {pc4_ID[31:28], jump_target, 2'b00}
                                        : {jr_addr[31:2], 2'b00};
   assign opcode   = instr_ID[31:26];
   assign funct    = instr_ID[5:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) estado <= ARRANQUE;
      else        estado <= estado_sig;
   end

   // Next-state: redirect and flush both force a clean return to FETCH
   always_comb begin
      estado_sig = estado;
      case (estado)
         ARRANQUE:  estado_sig = FETCH;
         FETCH:     if (transfer && stall) estado_sig = RETENCION;
         RETENCION: if (!stall) estado_sig = FETCH;
         default:   estado_sig = ARRANQUE;
      endcase
      if (redirect || resetIF) estado_sig = FETCH;
   end

   // Outputs: fetch only from FETCH, address is always the current PC
   always_comb begin
      imem_req  = (estado == FETCH) && MEM_RD_I;
      imem_addr = pc;
   end

   // Datapath control, priority: redirect/flush, then stall, then transfer
   always_comb begin
      pc_sig       = pc;
      if_load      = 1'b0;
      if_from_skid = 1'b0;
      if_nop       = 1'b0;
      skid_load    = 1'b0;
      if (redirect) begin
         pc_sig = target;
         if_nop = 1'b1;
      end else if (resetIF) begin
         if_nop = 1'b1;
      end else begin
         case (estado)
            FETCH: begin
               if (transfer) begin
                  pc_sig = pc_plus4;
                  if (stall) skid_load = 1'b1;
                  else       if_load   = 1'b1;
               end else if (!stall) begin
                  if_nop = 1'b1;
               end
            end
            RETENCION: if (!stall) if_from_skid = 1'b1;
            default: ;
         endcase
      end
   end

   // PC and skid buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         skid_instr <= 32'd0;
         skid_pc4   <= 32'd0;
      end else begin
         pc <= pc_sig;
         if (skid_load) begin
            skid_instr <= imem_rdata;
            skid_pc4   <= pc_plus4;
         end
      end
   end

   // IF/ID register; bubbles keep pc4_ID so jump targets stay anchored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_ID <= 32'd0;
         pc4_ID   <= 32'd0;
         valid_ID <= 1'b0;
      end else if (if_nop) begin
         instr_ID <= 32'd0;
         valid_ID <= 1'b0;
      end else if (if_load) begin
         instr_ID <= imem_rdata;
         pc4_ID   <= pc_plus4;
         valid_ID <= 1'b1;
      end else if (if_from_skid) begin
         instr_ID <= skid_instr;
         pc4_ID   <= skid_pc4;
         valid_ID <= 1'b1;
      end
   end

`ifdef IF_FETCH_CNT_EN
   // Delivery and stalled-valid-instruction counters, free-running and wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= 32'd0;
         stall_cnt <= 32'd0;
      end else begin
         if (if_load || if_from_skid) fetch_cnt <= fetch_cnt + 32'd1;
         if (stall && valid_ID)       stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_etapa_if.sv
// tb/tb_etapa_if.sv - scoreboard bench for etapa_if with a transaction-level fetch model
module tb_etapa_if;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  SEL_DIR = 2'b00;
   logic        resetIF = 1'b0;
   logic        MEM_RD_I = 1'b0;
   logic        stall = 1'b0;
   logic [25:0] jump_target = 26'd0;
   logic [31:0] jr_addr = 32'd0;
   logic [31:0] imem_rdata;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_addr, instr_ID, pc4_ID;
   logic        imem_req, valid_ID;
   logic [5:0]  opcode, funct;
`ifdef IF_FETCH_CNT_EN
   logic [31:0] fetch_cnt, stall_cnt;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // memory word equals its address
   assign imem_rdata = imem_addr;

   etapa_if #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst_n(rst_n), .SEL_DIR(SEL_DIR), .resetIF(resetIF),
      .MEM_RD_I(MEM_RD_I), .stall(stall), .jump_target(jump_target),
      .jr_addr(jr_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .imem_addr(imem_addr), .imem_req(imem_req), .instr_ID(instr_ID),
      .pc4_ID(pc4_ID), .valid_ID(valid_ID), .opcode(opcode), .funct(funct)
`ifdef IF_FETCH_CNT_EN
      , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic        req;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] fcnt;
      logic [31:0] scnt;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } word_t;

   exp_t  exp_q[$];
   word_t skid_q[$];

   bit          m_boot;
   logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_sc;
   logic        m_valid;

   function automatic void model_reset();
      m_boot = 1'b1; m_pc = RPC; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      m_fc = 32'd0; m_sc = 32'd0;
      skid_q.delete();
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // One clock of stimulus; the model predicts the post-edge view and queues it
   task automatic step(input logic rst, input logic [1:0] sel, input logic rif, input logic rd,
                       input logic stl, input logic rdy, input logic [25:0] jt, input logic [31:0] jr);
      exp_t  e;
      word_t w;
      bit    was_reset, fetching, redir;
      @(negedge clk);
      was_reset = !rst_n;
      rst_n = rst; SEL_DIR = sel; resetIF = rif; MEM_RD_I = rd; stall = stl;
      imem_ready = rdy; jump_target = jt; jr_addr = jr;
      if (!rst) begin
         model_reset();
      end else begin
         if (was_reset) begin
            #1;
            chk("arranque_req", {31'd0, imem_req}, 32'd0);
         end
         fetching = !m_boot && skid_q.size() == 0;
         redir    = !m_boot && (sel == 2'b01 || sel == 2'b10);
         if (stl && m_valid) m_sc = m_sc + 1;
         if (m_boot) begin
            m_boot = 1'b0;
            if (rif) begin m_instr = 32'd0; m_valid = 1'b0; end
         end else if (redir || rif) begin
            if (redir)
               m_pc = (sel == 2'b01) ? ((m_pc4 & 32'hF000_0000) | (32'(jt) << 2))
                                     : (jr & 32'hFFFF_FFFC);
            skid_q.delete();
            m_instr = 32'd0; m_valid = 1'b0;
         end else if (skid_q.size() != 0) begin
            if (!stl) begin
               w = skid_q.pop_front();
               m_instr = w.instr; m_pc4 = w.pc4; m_valid = 1'b1; m_fc = m_fc + 1;
            end
         end else if (fetching && rd && rdy) begin
            w.instr = m_pc; w.pc4 = m_pc + 4;
            m_pc = m_pc + 4;
            if (stl) skid_q.push_back(w);
            else begin m_instr = w.instr; m_pc4 = w.pc4; m_valid = 1'b1; m_fc = m_fc + 1; end
         end else if (!stl) begin
            m_instr = 32'd0; m_valid = 1'b0;
         end
      end
      e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
      e.fcnt = m_fc; e.scnt = m_sc;
      e.req = rst && !m_boot && skid_q.size() == 0 && rd;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 26'd0, 32'd0);
   endtask

   // Reset pulsed between edges: outputs must clear without a clock
   task automatic async_pulse();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_req", {31'd0, imem_req}, 32'd0);
      chk("async_valid", {31'd0, valid_ID}, 32'd0);
      chk("async_instr", instr_ID, 32'd0);
      chk("async_pc4", pc4_ID, 32'd0);
      chk("async_addr", imem_addr, RPC);
`ifdef IF_FETCH_CNT_EN
      chk("async_fetch_cnt", fetch_cnt, 32'd0);
      chk("async_stall_cnt", stall_cnt, 32'd0);
`endif
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // Monitor: pops one expectation per edge and compares the visible outputs
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (imem_addr !== e.pc || imem_req !== e.req) begin
               failures++;
               $display("FAIL fetch: addr=%h req=%b expected addr=%h req=%b", imem_addr, imem_req, e.pc, e.req);
            end
            checks++;
            if (instr_ID !== e.instr || pc4_ID !== e.pc4 || valid_ID !== e.valid ||
                opcode !== e.instr[31:26] || funct !== e.instr[5:0]) begin
               failures++;
               $display("FAIL ifid: instr=%h pc4=%h valid=%b op=%h fn=%h expected instr=%h pc4=%h valid=%b",
                        instr_ID, pc4_ID, valid_ID, opcode, funct, e.instr, e.pc4, e.valid);
            end
`ifdef IF_FETCH_CNT_EN
            checks++;
            if (fetch_cnt !== e.fcnt || stall_cnt !== e.scnt) begin
               failures++;
               $display("FAIL counters: fetch=%0d stall=%0d expected fetch=%0d stall=%0d",
                        fetch_cnt, stall_cnt, e.fcnt, e.scnt);
            end
`endif
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int r;
      logic [1:0] sel;
      model_reset();
      // reset, boot and sequential fetch
      step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 26'd0, 32'd0);
      step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 26'd0, 32'd0);
      run(3);
      // jump plus flush while pc4_ID = 8
      step(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 26'h40, 32'd0);
      run(3);
      // jr with unaligned register value
      step(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 26'd0, 32'h0000_0203);
      run(3);
      // stall for three cycles with a transfer on the first
      for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 26'd0, 32'd0);
      run(3);
      // memory not ready for four cycles, then ready with a flush on the same edge
      for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 26'd0, 32'd0);
      step(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 26'd0, 32'd0);
      run(2);
      // fresh reset, ten deliveries with two stalled cycles, then async reset
      step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 26'd0, 32'd0);
      run(6);
      for (int i = 0; i < 2; i++) step(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 26'd0, 32'd0);
      run(5);
      async_pulse();
      run(3);
      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 99);
         sel = (r < 6) ? 2'b01 : (r < 12) ? 2'b10 : (r < 16) ? 2'b11 : 2'b00;
         step(logic'($urandom_range(0, 99) != 0), sel, logic'($urandom_range(0, 99) < 7),
              logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 3) == 0),
              logic'($urandom_range(0, 9) < 7), 26'($urandom), 32'($urandom));
      end
      run(2);
      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/etapa_if.md
# etapa_if

Instruction-fetch stage of the pipelined MIPS core. It holds the program counter and runs a request/ready fetch handshake with instruction memory. It drives the IF/ID pipeline register whose `opcode`/`funct` fields feed the `ruta_ctrl` decoder. It consumes `ruta_ctrl`'s `SEL_DIR`, `resetIF` and `MEM_RD_I` to redirect, flush and gate fetch.

## Interface

**Parameters**
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

**Ports**
- `clk` input, 1 bit: single clock; everything is on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `SEL_DIR` input, 2 bits: next-PC select from `ruta_ctrl`.
  - 00: PC+4.
  - 01: jump.
  - 10: jr.
  - 11: treated as 00.
- `resetIF` input, 1 bit: flush IF/ID.
- `MEM_RD_I` input, 1 bit: fetch enable.
- `stall` input, 1 bit: hazard stall from downstream; holds IF/ID.
- `jump_target` input, 26 bits: J-type index field.
- `jr_addr` input, 32 bits: register value for jr.
- `imem_rdata` input, 32 bits: instruction word from memory.
- `imem_ready` input, 1 bit: memory data valid.
- `imem_addr` output, 32 bits: fetch address, equal to PC.
- `imem_req` output, 1 bit: fetch request.
- `instr_ID` output, 32 bits: IF/ID instruction.
- `pc4_ID` output, 32 bits: IF/ID PC+4.
- `valid_ID` output, 1 bit: IF/ID holds a real instruction.
- `opcode` output, 6 bits: `instr_ID[31:26]`.
- `funct` output, 6 bits: `instr_ID[5:0]`.

## Operation

- Next-PC arithmetic is modulo 2^32; `imem_addr[1:0]` is always 00.
  - PC+4: `pc+4`.
  - Jump: `{pc4_ID[31:28], jump_target, 2'b00}`.
  - jr: `{jr_addr[31:2], 2'b00}`.
- NOP is 32'h0000_0000.

**FSM states**
- `ARRANQUE`: one cycle after reset deassertion. `imem_req`=0. Goes to `FETCH` unconditionally.
- `FETCH`: `imem_req = MEM_RD_I`. A transfer occurs on an edge where `imem_req && imem_ready`.
  - Transfer with `stall`=0: IF/ID <= {`imem_rdata`, pc+4, valid=1}; PC <= pc+4.
  - Transfer with `stall`=1: data and pc+4 go to a one-entry skid buffer; PC <= pc+4; next state is `RETENCION`.
  - No transfer: PC holds. IF/ID takes NOP/valid=0 unless `stall`=1, in which case IF/ID holds.
- `RETENCION`: `imem_req`=0, IF/ID holds. On the first edge with `stall`=0: skid → IF/ID and the state returns to `FETCH`. No fetch is issued on that edge.

**Redirect**
- A redirect is an edge with `SEL_DIR` equal to 01 or 10, in any state except `ARRANQUE`.
- PC <= target. Any transfer accepted on that edge is discarded. The skid is cleared. The state goes to `FETCH`.
- Redirect beats stall.

**Flush**
- An edge with `resetIF`=1 loads IF/ID <= NOP, `valid_ID`=0 and `pc4_ID` holds. This overrides both stall and a simultaneous transfer.
- A flush without a redirect also clears the skid; the state goes to `FETCH` and PC holds.

**Simultaneous events, in priority order**
1. Reset.
2. Redirect / flush.
3. Stall.
4. Transfer.

## Timing

- Reset values:
  - PC = `RESET_PC`.
  - `imem_req`=0.
  - `instr_ID`=0, `pc4_ID`=0, `valid_ID`=0, `opcode`=0, `funct`=0.
  - Skid empty; state `ARRANQUE`.
- Reset asserted mid-transfer drops everything immediately, without waiting for an edge.
- `imem_addr` and `imem_req` are registered-state outputs, combinational from state and `MEM_RD_I`.
- Memory may return data in the same cycle as the request (`imem_ready` high) or wait any number of cycles. While waiting, `imem_addr` holds stable.
- Throughput: one instruction per cycle with zero-wait memory.
- Latency: an address presented in cycle N appears in `instr_ID` in cycle N+1.
- Redirect: the target address appears on `imem_addr` the cycle after the redirect edge.

## Configuration

- `IF_FETCH_CNT_EN` defined adds two 32-bit wrapping output counters, both reset to 0:
  - `fetch_cnt`: +1 per IF/ID load with valid=1.
  - `stall_cnt`: +1 per cycle with `stall`=1 and `valid_ID`=1.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan

- Reset with `RESET_PC`=0, `imem_ready`=1, `MEM_RD_I`=1, memory word = address. Required response:
  - `ARRANQUE` cycle with `imem_req`=0.
  - Then `imem_addr` 0, 4, 8.
  - `instr_ID` 0, 4, 8 one cycle later, with `valid_ID`=1.
- `SEL_DIR`=01, `jump_target`=26'h40, `resetIF`=1 while `pc4_ID`=32'h0000_0008. Required response:
  - Next `imem_addr` = 32'h0000_0100.
  - IF/ID = NOP with `valid_ID`=0.
  - The word in flight is never delivered.
- `SEL_DIR`=10 with `jr_addr`=32'h0000_0203 → `imem_addr` = 32'h0000_0200.
- `stall`=1 for 3 cycles with a transfer on the first. Required response:
  - `instr_ID` frozen.
  - `imem_req`=0 in `RETENCION`.
  - The skid word appears in `instr_ID` the edge after `stall` drops; fetch resumes at the skid's PC+4.
- `imem_ready` low for 4 cycles → `imem_addr` stable and IF/ID NOP/valid=0 throughout. Then `imem_ready`=1 plus `resetIF`=1 on the same edge → the word is discarded.
- `IF_FETCH_CNT_EN` build, 10 deliveries with 2 stall cycles → `fetch_cnt`=10, `stall_cnt`=2. Then `rst_n` pulsed low mid-cycle → both counters read 0 asynchronously.
